instr_mem_param: RTL

- Parametrised byte-organised instruction memory with a sequential word loader and a registered, handshaked fetch port.
- Sits between the boot/program loader and the fetch stage.
- Generalises the fixed 1 KiB/32-bit store with:
  - configurable depth, word width and base address
  - full and overflow tracking, with a loader restart
  - full-word little-endian fetch
  - a fetch-valid strobe and a fetch error on misaligned or out-of-range addresses.

---
 rtl/instr_mem_param.sv | 71 +++++++
 1 files changed

// File: rtl/instr_mem_param.sv
// instr_mem_param: byte-organised instruction memory with sequential word loader and registered fetch port
module instr_mem_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic                           load_restart,
  input  logic [DATA_W-1:0]              store,
  input  logic                           ready,
  input  logic [ADDR_W-1:0]              address,
  output logic [DATA_W-1:0]              instruction,
  output logic                           instr_valid,
  output logic                           fetch_err,
  output logic [$clog2(DEPTH_BYTES):0]   load_count,
  output logic                           load_full,
  output logic                           load_ovf
);
  localparam int BPW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int OW = $clog2(BPW);
  logic [7:0] mem [DEPTH_BYTES];
  logic [PW-1:0] ptr;
  logic [PW:0] nxt;
  logic [ADDR_W-1:0] off;
  logic legal, wr;
  logic [DATA_W-1:0] rd;
  assign nxt = {1'b0, ptr} + (PW+1)'(BPW);
  // addresses below the base wrap to large offsets and so fail the range test
  assign off = address - ADDR_W'(BASE_ADDR);
  assign legal = (off[OW-1:0] == '0) && (off < ADDR_W'(DEPTH_BYTES));
  assign wr = rst_n & load & ~load_restart & ~load_full;
  assign load_count = load_full ? (PW+1)'(DEPTH_BYTES) : {1'b0, ptr};
  always_comb begin
    rd = '0;
    for (int i = 0; i < BPW; i++) rd[8*i +: 8] = mem[off[PW-1:0] + PW'(i)];
  end
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < BPW; i++) mem[ptr + PW'(i)] <= store[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      load_full <= 1'b0;
      load_ovf <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      fetch_err <= 1'b0;
    end else if (load_restart) begin
      ptr <= '0;
      load_full <= 1'b0;
      load_ovf <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err <= 1'b0;
    end else if (load) begin
      instr_valid <= 1'b0;
      fetch_err <= 1'b0;
      if (load_full) load_ovf <= 1'b1;
      else begin
        ptr <= nxt[PW-1:0];
        load_full <= nxt == (PW+1)'(DEPTH_BYTES);
      end
    end else begin
      instr_valid <= ready;
      fetch_err <= ready & ~legal;
      if (ready) instruction <= legal ? rd : '0;
    end
endmodule
